s2mm_buf_sched: RTL and testbench

Frame-buffer scheduler and run controller for the S2MM video writer. It sequences the writer's soft reset from a user enable and hands the writer a base address for each frame. Buffers rotate so the writer never overwrites the frame the MM2S reader currently holds. It also tells the reader which buffer holds the newest complete frame. It sits between the register bank and the S2MM writer/MM2S reader pair, in the writer's AXI clock domain.

---
 rtl/s2mm_pkg.sv | 8 +
 rtl/s2mm_buf_sched_if.sv | 33 +++
 rtl/s2mm_buf_sched_buf_pick.sv | 24 ++
 rtl/s2mm_buf_sched.sv | 121 ++++++++++++
 tb/tb_s2mm_buf_sched.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/s2mm_pkg.sv
// s2mm_pkg: shared types and limits for the S2MM frame-buffer scheduler
package s2mm_pkg;
    localparam int IDX_W   = 2;
    localparam int BUF_MIN = 2;
    localparam int BUF_MAX = 4;
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
endpackage

// File: rtl/s2mm_buf_sched_if.sv
// s2mm_buf_sched_if: register-bank, writer and reader signals of the scheduler
interface s2mm_buf_sched_if #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_CNT_BITS   = 16
) ();
    logic                    enable;
    logic [C_ADDR_WIDTH-1:0] buf_base;
    logic [C_ADDR_WIDTH-1:0] buf_size;
    logic                    wr_soft_resetn;
    logic                    wr_resetting;
    logic                    wr_frame_pulse;
    logic [C_ADDR_WIDTH-1:0] wr_base_addr;
    logic                    rd_req;
    logic [C_ADDR_WIDTH-1:0] rd_base_addr;
    logic                    rd_valid;
    logic [1:0]              wr_idx;
    logic [1:0]              rd_idx;
    logic                    busy;
    logic [C_CNT_BITS-1:0]   frame_cnt;
    logic [C_CNT_BITS-1:0]   drop_cnt;

    modport master (
        output enable, buf_base, buf_size, wr_resetting, wr_frame_pulse, rd_req,
        input  wr_soft_resetn, wr_base_addr, rd_base_addr, rd_valid, wr_idx, rd_idx,
               busy, frame_cnt, drop_cnt
    );

    modport slave (
        input  enable, buf_base, buf_size, wr_resetting, wr_frame_pulse, rd_req,
        output wr_soft_resetn, wr_base_addr, rd_base_addr, rd_valid, wr_idx, rd_idx,
               busy, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/s2mm_buf_sched_buf_pick.sv
// buf_pick: lowest buffer index not excluded by the newest frame or the reader
module buf_pick
    import s2mm_pkg::*;
#(
    parameter int C_BUF_NUM = 3
) (
    input  idx_t excl_a,
    input  idx_t excl_b,
    input  logic excl_b_en,
    output idx_t idx,
    output logic found
);
    // scan downward so the lowest free index is the last one written
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = C_BUF_NUM - 1; i >= 0; i--) begin
            if (idx_t'(i) != excl_a && !(excl_b_en && idx_t'(i) == excl_b)) begin
                idx   = idx_t'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/s2mm_buf_sched.sv
// s2mm_buf_sched: writer run control and frame-buffer rotation for S2MM/MM2S
module s2mm_buf_sched
    import s2mm_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_BUF_NUM    = 3,
    parameter int C_CNT_BITS   = 16
) (
    input logic             M_AXI_ACLK,
    input logic             M_AXI_ARESET,
    s2mm_buf_sched_if.slave bus
);
    localparam int NB = C_BUF_NUM < BUF_MIN ? BUF_MIN : (C_BUF_NUM > BUF_MAX ? BUF_MAX : C_BUF_NUM);

    state_t                  state;
    logic                    soft_resetn;
    logic                    stop_hold;
    idx_t                    w, d, r, r_next, pick_idx;
    logic                    dv, rh, rh_next, take, pick_found, pulse, stop_exit;
    logic [C_ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [C_CNT_BITS-1:0]   frame_cnt, drop_cnt;

    function automatic logic [C_ADDR_WIDTH-1:0] idx_off(idx_t i, logic [C_ADDR_WIDTH-1:0] size);
        return ({C_ADDR_WIDTH{i[0]}} & size) + ({C_ADDR_WIDTH{i[1]}} & (size << 1));
    endfunction

    // reader hand-over happens first so the writer avoids the buffer the reader takes this cycle
    always_comb begin
        take      = bus.rd_req && dv;
        r_next    = take ? d : r;
        rh_next   = rh || take;
        pulse     = bus.wr_frame_pulse && state == RUN;
        stop_exit = state == STOP && stop_hold && !bus.wr_resetting;
    end

    buf_pick #(.C_BUF_NUM(NB)) u_pick (
        .excl_a    (w),
        .excl_b    (r_next),
        .excl_b_en (rh_next),
        .idx       (pick_idx),
        .found     (pick_found)
    );

    // run controller: release writer on enable, hold it in STOP for at least two cycles
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state       <= IDLE;
            soft_resetn <= 1'b0;
            stop_hold   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.enable && !bus.wr_resetting) begin
                    soft_resetn <= 1'b1;
                    state       <= RUN;
                end
                RUN: if (!bus.enable) begin
                    soft_resetn <= 1'b0;
                    stop_hold   <= 1'b0;
                    state       <= STOP;
                end
                STOP: if (!stop_hold) stop_hold <= 1'b1;
                      else if (!bus.wr_resetting) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // buffer rotation; reader index and hold survive a stop, writer restarts at buffer 0
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            w  <= '0;
            d  <= '0;
            r  <= '0;
            dv <= 1'b0;
            rh <= 1'b0;
        end else begin
            r  <= r_next;
            rh <= rh_next;
            if (stop_exit) begin
                w  <= '0;
                dv <= 1'b0;
            end else if (pulse) begin
                d  <= w;
                dv <= pick_found;
                if (pick_found) w <= pick_idx;
            end
        end
    end

    // statistics: completed frames and frames that had no free buffer to move to
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            frame_cnt <= pulse ? frame_cnt + 1'b1 : frame_cnt;
            drop_cnt  <= pulse && !pick_found ? drop_cnt + 1'b1 : drop_cnt;
        end
    end

    // base addresses registered from the current indices and buffer geometry
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else begin
            wr_addr <= bus.buf_base + idx_off(w, bus.buf_size);
            rd_addr <= bus.buf_base + idx_off(r, bus.buf_size);
        end
    end

    assign bus.wr_soft_resetn = soft_resetn;
    assign bus.wr_base_addr   = wr_addr;
    assign bus.rd_base_addr   = rd_addr;
    assign bus.rd_valid       = rh;
    assign bus.wr_idx         = w;
    assign bus.rd_idx         = r;
    assign bus.busy           = state != IDLE;
    assign bus.frame_cnt      = frame_cnt;
    assign bus.drop_cnt       = drop_cnt;
endmodule

// File: tb/tb_s2mm_buf_sched.sv
// tb_s2mm_buf_sched: directed checks of buffer rotation, run control and reset
module tb_s2mm_buf_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    s2mm_buf_sched_if #(.C_ADDR_WIDTH(32), .C_CNT_BITS(16)) a ();
    s2mm_buf_sched_if #(.C_ADDR_WIDTH(32), .C_CNT_BITS(16)) b ();

    s2mm_buf_sched #(.C_ADDR_WIDTH(32), .C_BUF_NUM(3), .C_CNT_BITS(16)) dut_a (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .bus          (a.slave)
    );

    s2mm_buf_sched #(.C_ADDR_WIDTH(32), .C_BUF_NUM(2), .C_CNT_BITS(16)) dut_b (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .bus          (b.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a();
        a.wr_frame_pulse = 1'b1;
        tick();
        a.wr_frame_pulse = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] seq1 [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        logic [1:0] seq2 [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
        a.enable = 0; a.wr_resetting = 0; a.wr_frame_pulse = 0; a.rd_req = 0;
        b.enable = 0; b.wr_resetting = 0; b.wr_frame_pulse = 0; b.rd_req = 0;
        a.buf_base = 32'h1000_0000; a.buf_size = 32'h0010_0000;
        b.buf_base = 32'h1000_0000; b.buf_size = 32'h0010_0000;
        tick();
        tick();
        check("rst_soft", a.wr_soft_resetn, 0);
        check("rst_busy", a.busy, 0);
        check("rst_rvalid", a.rd_valid, 0);
        check("rst_wbase", a.wr_base_addr, 0);
        check("rst_rbase", a.rd_base_addr, 0);
        check("rst_cnt", {a.frame_cnt, a.drop_cnt, a.wr_idx, a.rd_idx}, 0);

        // five frames, no reader: writer ping-pongs 0/1
        rst = 1'b0;
        a.enable = 1'b1;
        tick();
        check("run_busy", a.busy, 1);
        check("run_soft", a.wr_soft_resetn, 1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t1_widx%0d", k), a.wr_idx, seq1[k]);
            pulse_a();
        end
        check("t1_wbase_last", a.wr_base_addr, 32'h1000_0000);
        check("t1_fcnt", a.frame_cnt, 5);
        check("t1_widx_end", a.wr_idx, 1);
        check("t1_rvalid", a.rd_valid, 0);
        tick();
        check("t1_wbase_next", a.wr_base_addr, 32'h1010_0000);

        // reader takes buffer 0, writer rotates over 1/2
        do_reset();
        tick();
        pulse_a();
        a.rd_req = 1'b1;
        tick();
        a.rd_req = 1'b0;
        check("t2_ridx", a.rd_idx, 0);
        check("t2_rvalid", a.rd_valid, 1);
        tick();
        check("t2_rbase", a.rd_base_addr, 32'h1000_0000);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_widx%0d", k), a.wr_idx, seq2[k]);
            pulse_a();
        end
        check("t2_ridx_end", a.rd_idx, 0);

        // rd_req and frame pulse together with W=1, D=0
        do_reset();
        tick();
        pulse_a();
        a.rd_req = 1'b1;
        a.wr_frame_pulse = 1'b1;
        tick();
        a.rd_req = 1'b0;
        a.wr_frame_pulse = 1'b0;
        check("t3_ridx", a.rd_idx, 0);
        check("t3_widx", a.wr_idx, 2);
        tick();
        check("t3_rbase", a.rd_base_addr, 32'h1000_0000);
        check("t3_wbase", a.wr_base_addr, 32'h1020_0000);
        a.rd_req = 1'b1;
        tick();
        a.rd_req = 1'b0;
        check("t3_d_is_1", a.rd_idx, 1);
        tick();
        check("t3_rbase2", a.rd_base_addr, 32'h1010_0000);

        // two buffers: reader on 1, writer finishing 0 has nowhere to go
        do_reset();
        b.enable = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            b.wr_frame_pulse = 1'b1;
            tick();
            b.wr_frame_pulse = 1'b0;
        end
        b.rd_req = 1'b1;
        tick();
        b.rd_req = 1'b0;
        check("t4_ridx", b.rd_idx, 1);
        b.wr_frame_pulse = 1'b1;
        tick();
        b.wr_frame_pulse = 1'b0;
        check("t4_widx", b.wr_idx, 0);
        check("t4_rvalid", b.rd_valid, 1);
        check("t4_drop", b.drop_cnt, 1);
        check("t4_fcnt", b.frame_cnt, 3);
        b.rd_req = 1'b1;
        tick();
        b.rd_req = 1'b0;
        check("t4_ridx_kept", b.rd_idx, 1);
        b.enable = 1'b0;

        // stop with writer still resetting for 10 cycles
        do_reset();
        tick();
        pulse_a();
        check("t5_widx_pre", a.wr_idx, 1);
        a.enable = 1'b0;
        a.wr_resetting = 1'b1;
        tick();
        check("t5_soft", a.wr_soft_resetn, 0);
        repeat (9) tick();
        check("t5_busy_hold", a.busy, 1);
        a.wr_resetting = 1'b0;
        #1;
        check("t5_busy_fall", a.busy, 1);
        tick();
        check("t5_idle", a.busy, 0);
        check("t5_widx", a.wr_idx, 0);
        pulse_a();
        check("t5_idle_pulse", a.frame_cnt, 1);

        // short enable pulse still spends two cycles in STOP
        a.enable = 1'b1;
        tick();
        a.enable = 1'b0;
        tick();
        check("t5_short_stop", a.busy, 1);
        tick();
        check("t5_short_min", a.busy, 1);
        tick();
        check("t5_short_idle", a.busy, 0);

        // asynchronous reset mid-run
        a.enable = 1'b1;
        tick();
        pulse_a();
        a.rd_req = 1'b1;
        tick();
        a.rd_req = 1'b0;
        check("t6_pre_rvalid", a.rd_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_soft", a.wr_soft_resetn, 0);
        check("t6_busy", a.busy, 0);
        check("t6_rvalid", a.rd_valid, 0);
        check("t6_addr", {a.wr_base_addr, a.rd_base_addr}, 0);
        check("t6_idx_cnt", {a.wr_idx, a.rd_idx, a.frame_cnt, a.drop_cnt}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_restart_busy", a.busy, 1);
        check("t6_restart_soft", a.wr_soft_resetn, 1);
        check("t6_restart_widx", a.wr_idx, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
